lcd_text_buffer: RTL and testbench

- Character store directly upstream of the LCD sequencer. It supplies the 9-bit {RS, byte} word for whatever address the sequencer presents.
- The MIPS side writes it in two ways:
  - single ASCII characters;
  - a hex formatter FSM that expands a 32-bit value into 8 hex characters at a chosen position.
- Entry 22 holds the line-2 jump command, so the sequencer streams both display lines without special-casing.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_hex_formatter.sv | 95 +++++++++
 rtl/lcd_text_buffer.sv | 79 +++++++
 tb/tb_lcd_text_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, formatter state type and character helpers for the LCD text buffer.
package lcd_pkg;

  localparam logic [5:0] LINE1     = 6'd6;
  localparam logic [5:0] CH_LINE   = 6'd22;
  localparam logic [5:0] LINE2     = 6'd23;
  localparam logic [5:0] LAST      = 6'd38;
  localparam logic [8:0] SPACE_W   = 9'h120;
  localparam logic [8:0] LINE2_CMD = 9'h0C0;
  localparam logic [8:0] EMPTY_W   = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } fmt_state_t;

  function automatic logic is_writable(input logic [5:0] addr);
    return ((addr >= LINE1) && (addr < CH_LINE)) || ((addr >= LINE2) && (addr <= LAST));
  endfunction

  // 0x37 / 0x57 are the letter bases pre-offset by ten so one add covers A-F / a-f.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
    logic [7:0] base_v;
    if (nib < 4'd10) begin
      base_v = 8'h30;
    end else if (upper) begin
      base_v = 8'h37;
    end else begin
      base_v = 8'h57;
    end
    return base_v + {4'h0, nib};
  endfunction

endpackage

// File: rtl/lcd_hex_formatter.sv
// Expands a latched value into NDIGITS hex characters, one entry write per cycle, MSB first.
module lcd_hex_formatter
  import lcd_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b1,
  parameter int NDIGITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [5:0]             base,
  output logic                   busy,
  output logic                   done,
  output logic                   dig_we,
  output logic [5:0]             dig_addr,
  output logic [7:0]             dig_char
);

  localparam int VW = 4 * NDIGITS;
  localparam int KW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIGITS - 1);

  fmt_state_t      state_r;
  logic [VW-1:0]   value_r;
  logic [5:0]      base_r;
  logic [KW-1:0]   k_r;
  logic            busy_r;
  logic            done_r;

  // The digit in flight is always the top nibble of value_r; it shifts left once per written digit.
  assign busy     = busy_r;
  assign done     = done_r;
  assign dig_we   = busy_r;
  assign dig_addr = base_r + 6'(k_r);
  assign dig_char = nib2ascii(value_r[VW-1 -: 4], UPPER_HEX);

  // Formatter FSM: operand latch, digit counter and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      value_r <= '0;
      base_r  <= 6'd0;
      k_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clr) begin
      state_r <= IDLE;
      k_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            value_r <= value;
            base_r  <= base;
            k_r     <= '0;
            busy_r  <= 1'b1;
            state_r <= CONV;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CONV: begin
          value_r <= value_r << 3'd4;
          k_r     <= k_r + KW'(1);
          if (k_r == K_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= CONV;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_buffer.sv
// 64-entry {RS, byte} store read combinationally by the LCD sequencer; written directly or by the hex formatter.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b1,
  parameter int NDIGITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [5:0]           wr_addr,
  input  logic [7:0]           wr_char,
  output logic                 wr_ready,
  input  logic                 clr,
  input  logic                 hex_start,
  input  logic [4*NDIGITS-1:0] hex_value,
  input  logic [5:0]           hex_base,
  output logic                 hex_busy,
  output logic                 hex_done,
  input  logic [5:0]           address,
  output logic [8:0]           data_mem
);

  logic       dig_we_s;
  logic [5:0] dig_addr_s;
  logic [7:0] dig_char_s;
  logic       wr_acc_s;
  logic [8:0] mem_s [64];

  lcd_hex_formatter #(
    .UPPER_HEX (UPPER_HEX),
    .NDIGITS   (NDIGITS)
  ) u_fmt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (hex_start),
    .value    (hex_value),
    .base     (hex_base),
    .busy     (hex_busy),
    .done     (hex_done),
    .dig_we   (dig_we_s),
    .dig_addr (dig_addr_s),
    .dig_char (dig_char_s)
  );

  assign wr_ready = ~hex_busy;
  assign wr_acc_s = wr_en & wr_ready;
  assign data_mem = mem_s[address];

  // Only writable entries get storage; the line-2 jump and unused slots are fixed words.
  for (genvar i = 0; i < 64; i++) begin : g_entry
    if (is_writable(6'(i))) begin : g_rw
      logic [8:0] entry_r;

      // Per-entry write arbitration: clear beats a digit, a digit beats a direct write.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_r <= SPACE_W;
        end else if (clr) begin
          entry_r <= SPACE_W;
        end else if (dig_we_s && (dig_addr_s == 6'(i))) begin
          entry_r <= {1'b1, dig_char_s};
        end else if (wr_acc_s && (wr_addr == 6'(i))) begin
          entry_r <= {1'b1, wr_char};
        end else begin
          entry_r <= entry_r;
        end
      end

      assign mem_s[i] = entry_r;
    end else if (i == int'(CH_LINE)) begin : g_cmd
      assign mem_s[i] = LINE2_CMD;
    end else begin : g_none
      assign mem_s[i] = EMPTY_W;
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Scoreboard bench: stimulus queues expected reads/flags and done-pulse cycles; monitors pop and compare.
module tb_lcd_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_char;
  logic        wr_ready;
  logic        clr;
  logic        hex_start;
  logic [31:0] hex_value;
  logic [5:0]  hex_base;
  logic        hex_busy;
  logic        hex_done;
  logic [5:0]  address = 6'd0;
  logic [8:0]  data_mem;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         kind;   // 0 = memory read, 1 = hex_busy, 2 = wr_ready
    logic [5:0] addr;
    logic [8:0] exp;
    string      tag;
  } item_t;

  item_t rd_q[$];
  int    done_q[$];

  lcd_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .clr       (clr),
    .hex_start (hex_start),
    .hex_value (hex_value),
    .hex_base  (hex_base),
    .hex_busy  (hex_busy),
    .hex_done  (hex_done),
    .address   (address),
    .data_mem  (data_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read/flag monitor: drains the expectation queue on each falling edge.
  initial begin : rd_mon
    item_t      it;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      while (rd_q.size() > 0) begin
        it = rd_q.pop_front();
        if (it.kind == 0) begin
          address = it.addr;
          #1;
          act = data_mem;
        end else if (it.kind == 1) begin
          act = {8'h00, hex_busy};
        end else begin
          act = {8'h00, wr_ready};
        end
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s addr=%0d actual=%h required=%h", it.tag, it.addr, act, it.exp);
        end
      end
    end
  end

  // Done monitor: every hex_done pulse must match the next expected cycle.
  always @(negedge clk) begin : done_mon
    int exp_c;
    if (hex_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
      end else begin
        exp_c = done_q.pop_front();
        if (exp_c != cyc) begin
          bad++;
          $display("FAIL done_cycle actual=%0d required=%0d", cyc, exp_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_mem(input logic [5:0] a, input logic [8:0] e, input string t);
    rd_q.push_back('{0, a, e, t});
  endtask

  task automatic exp_flag(input int k, input logic v, input string t);
    rd_q.push_back('{k, 6'd0, {8'h00, v}, t});
  endtask

  task automatic drain();
    int n = 0;
    while (rd_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (rd_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", rd_q.size());
      rd_q.delete();
    end
    tick();
  endtask

  // Starts a conversion in the current cycle, scrambles the operands afterwards, checks busy/ready per cycle.
  task automatic run_hex(input logic [31:0] v, input logic [5:0] b);
    hex_value = v;
    hex_base  = b;
    hex_start = 1'b1;
    done_q.push_back(cyc + 9);
    tick();
    hex_start = 1'b0;
    wr_en     = 1'b0;
    hex_value = 32'hFFFF_FFFF;
    hex_base  = 6'd0;
    for (int i = 1; i <= 9; i++) begin
      exp_flag(1, (i <= 8), "busy_window");
      exp_flag(2, (i > 8), "ready_window");
      tick();
    end
    drain();
  endtask

  logic [8:0] beef_tab [8];
  logic [8:0] ff_tab   [8];

  initial begin : stim
    int c0;
    int acc_cyc;
    beef_tab = '{9'h144, 9'h145, 9'h141, 9'h144, 9'h142, 9'h145, 9'h145, 9'h146};
    ff_tab   = '{9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h146, 9'h146};
    rst = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_char = 8'h00; clr = 1'b0;
    hex_start = 1'b0; hex_value = 32'h0; hex_base = 6'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset contents and flags
    for (int a = 6; a <= 38; a++) begin
      if (a != 22) exp_mem(6'(a), 9'h120, "reset_space");
    end
    exp_mem(6'd22, 9'h0C0, "reset_line2_cmd");
    exp_mem(6'd3, 9'h000, "reset_low_unused");
    exp_mem(6'd63, 9'h000, "reset_high_unused");
    exp_flag(1, 1'b0, "reset_busy");
    exp_flag(2, 1'b1, "reset_ready");
    drain();

    // Direct writes, including dropped targets
    wr_en = 1'b1; wr_addr = 6'd7; wr_char = 8'h41;
    tick();
    wr_en = 1'b0;
    exp_mem(6'd7, 9'h141, "direct_write_next_cycle");
    drain();
    wr_en = 1'b1; wr_addr = 6'd22; wr_char = 8'h58;
    tick();
    wr_addr = 6'd40;
    tick();
    wr_en = 1'b0;
    exp_mem(6'd22, 9'h0C0, "write_22_dropped");
    exp_mem(6'd40, 9'h000, "write_40_dropped");
    exp_mem(6'd7, 9'h141, "entry7_kept");
    drain();

    // DEADBEEF on line 2
    run_hex(32'hDEAD_BEEF, 6'd23);
    for (int k = 0; k < 8; k++) exp_mem(6'(23 + k), beef_tab[k], "deadbeef_digit");
    drain();

    // Conversion straddling the line-2 command entry
    run_hex(32'h1234_5678, 6'd18);
    exp_mem(6'd18, 9'h131, "straddle_d1");
    exp_mem(6'd19, 9'h132, "straddle_d2");
    exp_mem(6'd20, 9'h133, "straddle_d3");
    exp_mem(6'd21, 9'h134, "straddle_d4");
    exp_mem(6'd22, 9'h0C0, "straddle_cmd_kept");
    exp_mem(6'd23, 9'h136, "straddle_d6");
    exp_mem(6'd24, 9'h137, "straddle_d7");
    exp_mem(6'd25, 9'h138, "straddle_d8");
    exp_mem(6'd26, 9'h144, "straddle_untouched");
    drain();

    // Same-cycle direct write and start colliding on entry 24: digit wins
    wr_en = 1'b1; wr_addr = 6'd24; wr_char = 8'h5A;
    run_hex(32'h0000_0001, 6'd24);
    exp_mem(6'd24, 9'h130, "collision_digit_wins");
    exp_mem(6'd31, 9'h131, "collision_last_digit");
    drain();

    // clr during the 4th CONV cycle aborts the conversion
    hex_value = 32'hABCD_EF01; hex_base = 6'd6; hex_start = 1'b1;
    tick();
    hex_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_flag(1, 1'b1, "clr_pre_busy");
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_flag(1, 1'b0, "clr_busy_dropped");
    exp_flag(2, 1'b1, "clr_ready");
    for (int a = 6; a <= 38; a++) begin
      if (a != 22) exp_mem(6'(a), 9'h120, "clr_space");
    end
    exp_mem(6'd22, 9'h0C0, "clr_cmd_kept");
    drain();
    repeat (10) tick();
    exp_flag(1, 1'b0, "clr_stays_idle");
    drain();

    // Start while busy is ignored; a held direct write stalls until busy drops
    hex_value = 32'h0000_00FF; hex_base = 6'd30; hex_start = 1'b1;
    c0 = cyc;
    done_q.push_back(c0 + 9);
    tick();
    hex_start = 1'b0;
    tick();
    hex_value = 32'h1111_1111; hex_base = 6'd6; hex_start = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd9; wr_char = 8'h5A;
    tick();
    hex_start = 1'b0;
    acc_cyc = -1;
    for (int n = 0; n < 20 && acc_cyc < 0; n++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) acc_cyc = cyc;
      tick();
    end
    wr_en = 1'b0;
    total++;
    if (acc_cyc != c0 + 9) begin
      bad++;
      $display("FAIL stalled_write_accept actual=%0d required=%0d", acc_cyc, c0 + 9);
    end
    repeat (12) tick();
    for (int k = 0; k < 8; k++) exp_mem(6'(30 + k), ff_tab[k], "ff_digit");
    exp_mem(6'd9, 9'h15A, "stalled_write_landed");
    exp_mem(6'd6, 9'h120, "ignored_start_no_write");
    exp_mem(6'd38, 9'h120, "entry38_untouched");
    drain();

    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL missing_done actual=%0d required=0", done_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
